// File: rtl/alu_pipe.sv
// Sequential ALU with valid/ready handshakes, registered result and status flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 11); otherwise opcode 11 is illegal.
module alu_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             err,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on any rising edge where valid && ready are both high.
  // The source holds its payload while valid && !ready; out1/flags/err are held while out_valid && !out_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MUL_EN
    , S_BUSY = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d, err_q, err_d;
  logic             accept;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;

`ifdef ALU_MUL_EN
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW:0]       cnt_q, cnt_d;
`endif

  assign in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == S_DONE);
  assign out1        = out1_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;
  assign flag_v      = v_q;
  assign flag_n      = n_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

  assign sum   = {1'b0, in1} + {1'b0, in2};
  assign diff  = {1'b0, in1} - {1'b0, in2};
  assign shamt = in2[SHW-1:0];

  // Single-cycle operations; anything not decoded here is reported as illegal.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (sel)
      4'd0: alu_res = in1 & in2;
      4'd1: alu_res = in1 | in2;
      4'd2: alu_res = in1 ^ in2;
      4'd3: alu_res = ~(in1 ^ in2);
      4'd4: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      4'd5: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      4'd6:  alu_res = in1 << shamt;
      4'd7:  alu_res = in1 >> shamt;
      4'd8:  alu_res = $signed(in1) >>> shamt;
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out1_d  = out1_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready && !in_valid) state_d = S_IDLE;
        if (accept) begin
`ifdef ALU_MUL_EN
          if (sel == 4'd11) begin
            state_d  = S_BUSY;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, in1};
            mplier_d = in2;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d = S_DONE;
            out1_d  = alu_res;
            z_d     = !alu_err && (alu_res == '0);
            c_d     = alu_c;
            v_d     = alu_v;
            n_d     = alu_res[WIDTH-1];
            err_d   = alu_err;
          end
        end
      end
`ifdef ALU_MUL_EN
      // WIDTH add/shift iterations, then one cycle to publish the product.
      S_BUSY: begin
        if (cnt_q != CNT_LAST) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + (SHW+1)'(1);
        end else begin
          state_d = S_DONE;
          out1_d  = acc_q[WIDTH-1:0];
          z_d     = (acc_q[WIDTH-1:0] == '0);
          c_d     = |acc_q[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          n_d     = acc_q[WIDTH-1];
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out1_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      out1_q  <= out1_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random bench for alu_pipe (WIDTH=8) with an expected-result queue.
// Multiplier cases are built when ALU_MUL_EN is defined, illegal-opcode-11 cases otherwise.
module tb_alu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in1, in2, out1;
  logic [3:0]   sel;
  logic         flag_z, flag_c, flag_v, flag_n, err;
  logic [1:0]   dbg_state;

  // Packed result: {out1, z, c, v, n, err}
  logic [W+4:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n),
    .err(err), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W+4:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op);
    logic [W-1:0]   r;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic           c, v, e;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~(a ^ b);
      4'd4: begin s = a + b; r = s[W-1:0]; c = s[W]; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'd5: begin r = a - b; c = (a < b); v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'd6: r = a << b[2:0];
      4'd7: r = a >> b[2:0];
      4'd8: begin
        r = a;
        for (int k = 0; k < int'(b[2:0]); k++) r = {a[W-1], r[W-1:1]};
      end
      4'd9:  r = {{(W-1){1'b0}}, ((a[W-1] != b[W-1]) ? a[W-1] : (a < b))};
      4'd10: r = {{(W-1){1'b0}}, (a < b)};
`ifdef ALU_MUL_EN
      4'd11: begin p = a * b; r = p[W-1:0]; c = |p[2*W-1:W]; end
`endif
      default: e = 1'b1;
    endcase
    return {r, (!e && r == '0), c, v, r[W-1], e};
  endfunction

  // Driver: present one op from a negedge, hold until accepted, return at the negedge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    int n;
    in1 = a; in2 = b; sel = op; in_valid = 1'b1;
    exp_q.push_back(model(a, b, op));
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard: wait (bounded) for a result and compare against the queue head.
  task automatic get_result(input string tag);
    int n;
    logic [W+4:0] e;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk); n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_pending"}, (exp_q.size() != 0), 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, {out1, flag_z, flag_c, flag_v, flag_n, err}, e);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        input string tag);
    send(a, b, op);
    get_result(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; sel = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", {out1, flag_z, flag_c, flag_v, flag_n, err}, '0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    #1 check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // ADD with carry and zero, 1-cycle latency
    send(8'hFF, 8'h01, 4'd4);
    check("add_latency", out_valid, 1'b1);
    check("add_out1", out1, 8'h00);
    check("add_zcv", {flag_z, flag_c, flag_v}, 3'b110);
    get_result("add");
    @(negedge clk);

    send(8'h80, 8'h01, 4'd5);
    check("sub_out1", out1, 8'h7F);
    check("sub_vcn", {flag_v, flag_c, flag_n}, 3'b100);
    get_result("sub");
    @(negedge clk);

    send(8'h90, 8'h02, 4'd8);
    check("sra_out1", out1, 8'hE4);
    check("sra_n", flag_n, 1'b1);
    get_result("sra");
    @(negedge clk);

    send(8'hFF, 8'h01, 4'd9);
    check("slt_out1", out1, 8'h01);
    get_result("slt");
    @(negedge clk);

    run_op(8'hFF, 8'h01, 4'd10, "sltu");
    run_op(8'h81, 8'h03, 4'd6, "sll");
    run_op(8'h81, 8'h07, 4'd7, "srl");
    run_op(8'h7F, 8'h01, 4'd4, "add_ovf");
    run_op(8'h00, 8'h01, 4'd5, "sub_borrow");
    run_op(8'hA5, 8'h5A, 4'd3, "xnor");

    send(8'h12, 8'h34, 4'hF);
    check("illegal_out1", out1, 8'h00);
    check("illegal_err", err, 1'b1);
    get_result("illegal");
    @(negedge clk);

`ifdef ALU_MUL_EN
    send(8'h10, 8'h11, 4'd11);
    for (int i = 0; i <= W; i++) begin
      check("mul_busy_valid", out_valid, 1'b0);
      check("mul_busy_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    check("mul_latency", out_valid, 1'b1);
    check("mul_out1", out1, 8'h10);
    check("mul_c", flag_c, 1'b1);
    get_result("mul");
    @(negedge clk);
`else
    send(8'h10, 8'h11, 4'd11);
    check("op11_latency", out_valid, 1'b1);
    check("op11_err", err, 1'b1);
    get_result("op11");
    @(negedge clk);
`endif

    // Backpressure: result held while a second op waits
    out_ready = 1'b0;
    send(8'h03, 8'h04, 4'd4);
    get_result("bp_add");
    in1 = 8'hF0; in2 = 8'h0F; sel = 4'd2; in_valid = 1'b1;
    exp_q.push_back(model(8'hF0, 8'h0F, 4'd2));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_out1", out1, 8'h07);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_xor_next", out_valid, 1'b1);
    check("bp_xor_out1", out1, 8'hFF);
    get_result("bp_xor");
    @(negedge clk);

    // Streaming: one result per cycle with out_ready high
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 10));
      in1 = ra; in2 = rb; sel = rop; in_valid = 1'b1;
      exp_q.push_back(model(ra, rb, rop));
      @(negedge clk);
      check("stream_valid", out_valid, 1'b1);
      get_result("stream");
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_idle", dbg_state, 2'd0);

    // Random single ops, any opcode
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      run_op(ra, rb, rop, "rand");
    end

    // Reset while an operation is in flight drops it
`ifdef ALU_MUL_EN
    send(8'h03, 8'h05, 4'd11);
    repeat (3) @(negedge clk);
`else
    out_ready = 1'b0;
    send(8'h09, 8'h09, 4'd4);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    check("abort_valid", out_valid, 1'b0);
    check("abort_state", dbg_state, 2'd0);
    send(8'h01, 8'h01, 4'd4);
    check("post_rst_out1", out1, 8'h02);
    get_result("post_rst");
    @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised sequential ALU, successor to the lab's 8-bit combinational ALU. It extends that ALU with:
- configurable operand width;
- a valid/ready handshake on input and output;
- a registered result with status flags;
- extra shift and compare operations;
- an optional iterative multi-cycle multiplier.

It sits between an operand source (register file or testbench driver) and a result consumer. It holds one operation in flight.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount for shifts
- sel  input  4  opcode
- out_valid  output  1  result registered and held
- out_ready  input  1  consumer takes result this cycle
- out1  output  WIDTH  result
- flag_z  output  1  result == 0
- flag_c  output  1  carry/borrow/product overflow
- flag_v  output  1  signed overflow
- flag_n  output  1  result MSB
- err  output  1  illegal or disabled opcode

## Operation
- An operation is accepted on a cycle with in_valid && in_ready. in1, in2 and sel are captured on that edge.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR
  - 4 ADD, 5 SUB (in1−in2)
  - 6 SLL, 7 SRL, 8 SRA (arithmetic)
  - 9 SLT (signed), 10 SLTU: result is 1 or 0, zero-extended
  - 11 MUL: low WIDTH bits of the unsigned product
  - 12–15 illegal
- Flags:
  - ADD: flag_c = carry out; flag_v = signed overflow.
  - SUB: flag_c = borrow (in1 < in2 unsigned); flag_v = signed overflow.
  - MUL: flag_c = 1 if any of the upper WIDTH product bits is nonzero; flag_v = 0.
  - All other ops: flag_c = flag_v = 0.
  - flag_z and flag_n are always computed from out1.
- Illegal opcode: out1 = 0, err = 1, all flags 0, single-cycle path.
- FSM states:
  - IDLE: in_ready = 1.
    - Accepting a non-MUL op → DONE.
    - Accepting MUL → BUSY.
  - BUSY: shift-add multiplier, one multiplier bit per cycle. After WIDTH iterations → DONE. in_ready = 0.
  - DONE: out_valid = 1; out1, flags and err are held stable. in_ready = out_ready.
    - If out_ready && in_valid, the new op is accepted in the same cycle. Next state is DONE (non-MUL) or BUSY (MUL).
    - If out_ready && !in_valid → IDLE.
- Reset: state = IDLE, out_valid = 0, out1 = 0, all flags 0, err = 0, multiplier accumulator cleared.
- Reset asserted in BUSY or DONE aborts or drops the operation. No result is emitted.

## Timing
- Non-MUL latency: out_valid rises on the edge following acceptance, i.e. 1 cycle.
- MUL latency: out_valid rises WIDTH+1 cycles after acceptance.
- Throughput with out_ready held high: one non-MUL result per cycle. MUL occupies WIDTH+1 cycles.
- Output signals do not change while out_valid && !out_ready.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.

## Configuration
- ALU_MUL_EN defined: MUL opcode 11 is implemented as above, including the BUSY state and the 2·WIDTH accumulator.
- ALU_MUL_EN undefined: opcode 11 is treated as illegal (out1 = 0, err = 1, 1-cycle latency). The BUSY state and the multiplier logic are not synthesised.

## Test plan
- WIDTH=8, ADD 0xFF + 0x01 → out1 = 0x00, flag_z = 1, flag_c = 1, flag_v = 0, out_valid 1 cycle after accept.
- SUB 0x80 − 0x01 → out1 = 0x7F, flag_v = 1, flag_c = 0, flag_n = 0. Also SRA 0x90 by in2 = 0x02 → out1 = 0xE4, flag_n = 1. Also SLT 0xFF vs 0x01 → out1 = 0x01.
- With ALU_MUL_EN: MUL 0x10 × 0x11 → out1 = 0x10, flag_c = 1, out_valid exactly 9 cycles after accept, in_ready = 0 throughout BUSY.
- Backpressure: ADD 0x03 + 0x04, then hold out_ready = 0 for 3 cycles with in_valid high and a second op XOR 0xF0 ^ 0x0F. Required: out1 = 0x07 is stable and in_ready = 0 during the stall. Raising out_ready accepts the XOR the same cycle, giving out1 = 0xFF on the next cycle.
- Illegal sel = 0xF → out1 = 0x00, err = 1. Without ALU_MUL_EN, sel = 11 → err = 1 after 1 cycle.
- Assert rst for 1 cycle during MUL BUSY → out_valid stays 0 and state returns to IDLE. A new ADD 0x01 + 0x01 is accepted the next cycle → out1 = 0x02.
